fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_pkg.sv | 19 +
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx_baud.sv | 31 +++
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 tb/tb_fifo_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx shared types and line-level constants.
// State encoding and 8N1 frame levels.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between syn_fifo and its consumer.
// master = consumer (pops), slave = FIFO.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_is_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_r_data;

  modport master (
    output fifo_r_en,
    input  fifo_is_empty,
    input  fifo_r_data
  );

  modport slave (
    input  fifo_r_en,
    output fifo_is_empty,
    output fifo_r_data
  );

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period generator: counts 0..div_q, ticks at div_q.
// div_q is captured on load so a frame keeps one bit period.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;

  assign tick = run && (cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a syn_fifo read port.
// txd is a flop fed from next state, so it never glitches.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  fifo_uart_tx_if.master       fifo,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_WIDTH - 1);

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [CW-1:0]         bit_cnt, bit_d;
  logic                  txd_d;
  logic                  tick;
  logic                  go;

  assign go        = enable && !fifo.fifo_is_empty;
  assign fifo.fifo_r_en = (state == POP);
  assign busy      = (state != IDLE);

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == LOAD),
    .run  (state inside {START, DATA, STOP}),
    .div  (baud_div),
    .tick (tick)
  );

  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d   = bit_cnt;
    tx_done = 1'b0;
    unique case (state)
      IDLE:  if (go) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        shift_d = fifo.fifo_r_data;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_cnt + CW'(1);
            shift_d = shift >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tx_done = 1'b1;
          state_d = go ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d = IDLE_LEVEL;
    case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[0];
      STOP:    txd_d = STOP_BIT;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= IDLE_LEVEL;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_d;
      txd     <= txd_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue FIFO, frame-level model,
// per-cycle compare plus directed literal checks.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [VW-1:0] baud_div = '0;
  logic          txd, busy, tx_done;

  int checks = 0;
  int errors = 0;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus();

  fifo_uart_tx #(
    .DATA_WIDTH(DW),
    .DIV_WIDTH (VW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .baud_div(baud_div),
    .fifo    (bus.master),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // environment FIFO (fq) and the model's own copy (mq)
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];

  assign bus.fifo_is_empty = (fq.size() == 0);

  always @(posedge clk)
    if (bus.fifo_r_en && fq.size() != 0)
      bus.fifo_r_data <= fq.pop_front();

  task automatic push(input logic [DW-1:0] b);
    fq.push_back(b);
    mq.push_back(b);
  endtask

  // model: 0 idle, 1 pop, 2 load, 3 frame (t = cycle in frame)
  int ph = 0;
  int t = 0;
  int dq = 0;
  logic [DW-1:0] mb = '0;

  function automatic int flen(input int d);
    return FRAME_BITS * (d + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      t = 0;
    end else begin
      case (ph)
        0: if (enable && mq.size() > 0) ph = 1;
        1: begin
          mb = mq.pop_front();
          ph = 2;
        end
        2: begin
          dq = int'(baud_div);
          t = 0;
          ph = 3;
        end
        default: begin
          if (t == flen(dq) - 1)
            ph = (enable && mq.size() > 0) ? 1 : 0;
          else
            t++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [9:0] fw;
    logic       etxd;
    if (rst_n) begin
      fw = {1'b1, mb, 1'b0};
      etxd = (ph == 3) ? fw[t / (dq + 1)] : 1'b1;
      chk("txd", int'(txd), int'(etxd));
      chk("busy", int'(busy), int'(ph != 0));
      chk("r_en", int'(bus.fifo_r_en), int'(ph == 1));
      chk("tx_done", int'(tx_done),
          int'(ph == 3 && t == flen(dq) - 1));
    end
  end

  int pops = 0;
  int dones = 0;
  int busys = 0;

  always @(negedge clk)
    if (rst_n) begin
      pops  += int'(bus.fifo_r_en);
      dones += int'(tx_done);
      busys += int'(busy);
    end

  int p0, d0, b0;

  task automatic snap();
    @(negedge clk);
    #1;
    p0 = pops;
    d0 = dones;
    b0 = busys;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v,
                           input int lim,
                           input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (busy === v) return;
    end
    chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic wait_ren(input int lim,
                          input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.fifo_r_en === 1'b1) return;
    end
    chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic wait_low(input int lim,
                          input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (txd === 1'b0) return;
    end
    chk({nm, "_timeout"}, 1, 0);
  endtask

  initial begin
    logic [9:0] pat;
    logic       wv[40];
    logic       dlast;
    int         bad;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_r_en", int'(bus.fifo_r_en), 0);
    chk("rst_done", int'(tx_done), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    enable = 1'b1;

    // empty FIFO, enabled: nothing happens
    repeat (100) @(negedge clk);
    #1;
    chk("idle_pops", pops, 0);
    chk("idle_txd", int'(txd), 1);
    chk("idle_busy", int'(busy), 0);

    // single 0xA5 at 4-cycle bits
    snap();
    baud_div = 4'd3;
    push(8'hA5);
    pat = 10'b1101001010;
    wait_low(20, "a5_start");
    wv[0] = txd;
    dlast = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      wv[k] = txd;
      if (k == 39) dlast = tx_done;
    end
    bad = 0;
    for (int k = 0; k < 40; k++)
      if (wv[k] !== pat[k / 4]) bad++;
    chk("a5_wave_bad", bad, 0);
    chk("a5_done_last", int'(dlast), 1);
    wait_busy(1'b0, 50, "a5_end");
    settle();
    chk("a5_pops", pops - p0, 1);
    chk("a5_dones", dones - d0, 1);
    chk("a5_busy", busys - b0, 42);
    chk("a5_empty", fq.size(), 0);

    // back-to-back, 1-cycle bits
    snap();
    baud_div = 4'd0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_busy(1'b1, 20, "b2b_go");
    wait_busy(1'b0, 200, "b2b_end");
    settle();
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_dones", dones - d0, 3);
    chk("b2b_busy", busys - b0, 36);

    // maximum divider: 16-cycle bits
    snap();
    baud_div = 4'hF;
    push(8'h96);
    wait_busy(1'b1, 20, "max_go");
    wait_busy(1'b0, 400, "max_end");
    settle();
    chk("max_busy", busys - b0, 162);
    chk("max_dones", dones - d0, 1);

    // enable drop during frame 2 DATA
    snap();
    baud_div = 4'd7;
    push(8'h11);
    push(8'h22);
    push(8'h81);
    push(8'h5A);
    wait_ren(20, "en_pop1");
    wait_ren(200, "en_pop2");
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, 200, "en_end");
    repeat (5) @(negedge clk);
    settle();
    chk("en_pops", pops - p0, 2);
    chk("en_dones", dones - d0, 2);
    chk("en_avail", fq.size(), 2);
    chk("en_busy", busys - b0, 164);

    // reset during DATA of 0x81, then 0x5A
    snap();
    baud_div = 4'd3;
    enable = 1'b1;
    wait_ren(20, "rm_pop");
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_txd", int'(txd), 1);
    chk("rm_busy", int'(busy), 0);
    chk("rm_r_en", int'(bus.fifo_r_en), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wait_busy(1'b1, 20, "rm_go");
    wait_busy(1'b0, 100, "rm_end");
    settle();
    chk("rm_pops", pops - p0, 2);
    chk("rm_dones", dones - d0, 1);
    chk("rm_empty", fq.size(), 0);

    // divider change mid-frame
    snap();
    baud_div = 4'd1;
    push(8'h33);
    push(8'hC4);
    wait_low(20, "bd_start");
    repeat (6) @(negedge clk);
    baud_div = 4'd5;
    wait_busy(1'b0, 300, "bd_end");
    settle();
    chk("bd_busy", busys - b0, 84);
    chk("bd_dones", dones - d0, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
